apb_dp_mem_v2: RTL and testbench
================================

Name: apb_dp_mem_v2

Overview:
- Parametrised APB4 completer memory with a second, independent, registered read port (port B) for a local consumer.
- Adds the following to the APB memory slave:
  - configurable width, depth and wait states;
  - byte-addressed PADDR with an alignment check;
  - a read-only window;
  - out-of-range and illegal-strobe errors;
  - protocol-violation abort;
  - a saturating error counter.
- Sits behind the APB interconnect as a shared buffer between software (APB) and datapath logic (port B).

Parameters:
- DATA_WIDTH, 32, data bits; multiple of 8, range 8..64.
- DEPTH, 256, number of words; need not be a power of 2.
- PADDR_W, 12, PADDR width in bits (byte address).
- RD_WAIT, 1, wait states inserted on a legal read (0..15).
- WR_WAIT, 3, wait states inserted on a legal write (0..15).
- RO_BASE, 'h40, first word index of the read-only window.
- RO_LIMIT, 'h4F, last word index of the read-only window (inclusive); RO_LIMIT<RO_BASE disables the window.

Ports:
- PCLK in 1: clock.
- PRESET in 1: asynchronous, active-high reset.
- PSEL in 1: APB select.
- PENABLE in 1: APB enable.
- PWRITE in 1: 1=write, 0=read.
- PADDR in PADDR_W: byte address.
- PWDATA in DATA_WIDTH: write data.
- PSTRB in DATA_WIDTH/8: byte write strobes.
- PRDATA out DATA_WIDTH: read data.
- PREADY out 1: transfer completes.
- PSLVERR out 1: transfer error; valid only when PREADY=1.
- b_en in 1: port B read request.
- b_addr in $clog2(DEPTH): port B word index.
- b_rdata out DATA_WIDTH: port B data, registered.
- b_rvalid out 1: b_rdata valid, one cycle after b_en.
- b_err out 1: port B address out of range; qualifies b_rvalid.
- err_cnt out 8: count of APB error completions plus protocol aborts; saturates at 255.

Behaviour:
- Reset (PRESET=1, asynchronous):
  - FSM=IDLE, wait counter=0;
  - PREADY=0, PSLVERR=0, PRDATA=0;
  - b_rvalid=0, b_err=0, b_rdata=0, err_cnt=0.
  - Memory contents are not reset.
  - Reset mid-transfer drops any pending write; memory is untouched.
- Address decode:
  - LSB = $clog2(DATA_WIDTH/8); word index = PADDR[PADDR_W-1:LSB].
  - misaligned = PADDR[LSB-1:0] != 0.
  - oor = word index >= DEPTH.
- Error classification, evaluated at SETUP:
  - err = misaligned | oor | (PWRITE & index in [RO_BASE,RO_LIMIT]) | (!PWRITE & PSTRB!=0).
- FSM states: IDLE, ACCESS, ABORT.
  - IDLE: on PSEL&!PENABLE (setup phase), latch PWRITE, index and err. Load the counter with 0 if err, else WR_WAIT or RD_WAIT. Go to ACCESS.
  - ACCESS:
    - PREADY = (cnt==0) & PSEL & PENABLE. While cnt!=0, decrement.
    - On PREADY, go to IDLE. Back-to-back setup in the next cycle is legal and is handled by IDLE.
    - Latency: completion in ACCESS cycle number (wait+1). Zero-wait transfers complete in the first ACCESS cycle.
  - ABORT (protocol violation): entered from ACCESS if PSEL=0, PENABLE=0, or PADDR/PWRITE differ from the latched values.
    - No write; err_cnt increments.
    - Outputs idle; returns to IDLE next cycle.
- Write commit:
  - Happens on the PCLK edge ending the PREADY=1 cycle, only if !err.
  - Byte lanes with PSTRB[i]=1 are updated; PSTRB=0 is a legal no-op write.
- Read data:
  - PRDATA = mem[index] only while PREADY=1 & !PWRITE & !err; otherwise 0.
- Errors:
  - A completing error transfer has PREADY=1 and PSLVERR=1 in the first ACCESS cycle.
  - No memory update; PRDATA=0; err_cnt+1 (saturating).
  - PSLVERR is 0 whenever PREADY=0.
- Port B:
  - b_en at edge N gives b_rvalid=1 at edge N+1 with b_rdata=mem[b_addr].
  - If b_addr>=DEPTH: b_err=1, b_rdata=0.
  - b_rvalid is a single-cycle pulse per request; requests every cycle are accepted.
- Collision: an APB write commit and a port-B read of the same word on the same edge returns the OLD data (read-before-write). The new data is visible to port B from the next request.

Decomposition:
- apb_pkg additions:
  - apb_mem_state_t {IDLE, ACCESS, ABORT};
  - ERR_CNT_W=8 constant;
  - function is_misaligned().
- One sub-module: apb_dp_mem_v2_ram, the storage array.
  - One byte-enabled write port and two read ports: APB combinational, B registered read-before-write.
  - Isolates the array for later SRAM-macro substitution.

Test Plan:
- Write then read, normal path:
  - Write 'hDEADBEEF to PADDR 'h010 with PSTRB 'hF. Expect PREADY in the 4th ACCESS cycle and PSLVERR=0.
  - Read back 'h010. Expect PREADY in the 2nd ACCESS cycle with PRDATA='hDEADBEEF.
- Partial strobe:
  - Write 'h11223344 to 'h020 with PSTRB 'hF, then 'hAABBCCDD with PSTRB 'b0101.
  - Read 'h020. Expect 'h11BB33DD.
- Error cases (each: PREADY+PSLVERR in the 1st ACCESS cycle, memory unchanged, err_cnt increments, final err_cnt=4):
  - write to 'h100 (word 'h40, read-only);
  - read of 'h402 (misaligned);
  - read of 'h400 (word 256, out of range);
  - read of 'h010 with PSTRB='h1.
- Port B collision:
  - Preload word 5='h1, then APB write 'h2 to it.
  - b_en=1, b_addr=5 on the commit edge gives b_rdata='h1. The next request gives 'h2.
  - b_addr=300 gives b_rvalid=1, b_err=1, b_rdata=0.
- Protocol abort: drop PSEL in the 2nd ACCESS cycle of a write to 'h030. Expect no memory change, err_cnt+1, FSM returns to IDLE and accepts the next transfer.
- Reset mid-write: assert PRESET during the 2nd ACCESS cycle of a write to 'h040. Expect outputs 0 immediately (asynchronous) and word 'h10 keeps its old value after release.

Source files
------------

// File: rtl/apb_dp_mem_v2_pkg.sv
// Shared types and helpers for the APB dual-port memory.
//   apb_mem_state_t : APB completer FSM states
//   ERR_CNT_W       : width of the saturating error counter
//   is_misaligned() : true when the byte address is not word aligned
package apb_dp_mem_v2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ABORT  = 2'd2
    } apb_mem_state_t;

    localparam int ERR_CNT_W = 8;

    // lsb is log2 of the word size in bytes; with byte-wide words
    // (lsb = 0) the mask is empty and nothing is ever misaligned.
    function automatic logic is_misaligned(input logic [63:0] addr, input int lsb);
        logic [63:0] mask;
        mask = (64'd1 << lsb) - 64'd1;
        return (addr & mask) != 64'd0;
    endfunction

endpackage

// File: rtl/apb_dp_mem_v2_ram.sv
// Storage array for apb_dp_mem_v2, kept separate so it can be swapped
// for an SRAM macro.
//   clk, rst        : clock, async active-high reset (port B register only)
//   we, wbe, wdata  : byte-enabled write at a_addr
//   a_addr, a_rdata : combinational read port (APB side)
//   b_en, b_addr    : registered read request (local consumer)
//   b_rdata         : registered read data, old data on a same-edge write
module apb_dp_mem_v2_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]           a_addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic                    b_en,
    input  logic [AW-1:0]           b_addr,
    output logic [DATA_WIDTH-1:0]   b_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would force it into flops
    // and rule out a macro. Only the port B output register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (wbe[i]) begin
                    mem[a_addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign a_rdata = mem[a_addr];

    // Reading mem here with a non-blocking update gives read-before-write
    // when port B hits the word being committed on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rdata <= '0;
        end else if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/apb_dp_mem_v2.sv
// APB4 completer memory with an independent registered read port (B).
//   PCLK, PRESET            : clock, async active-high reset
//   PSEL..PSTRB             : APB4 request (byte address in PADDR)
//   PRDATA, PREADY, PSLVERR : APB4 response
//   b_en, b_addr            : port B word read request
//   b_rdata, b_rvalid, b_err: port B response, one cycle after b_en
//   err_cnt                 : saturating count of error completions + aborts
module apb_dp_mem_v2
    import apb_dp_mem_v2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int PADDR_W    = 12,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 3,
    parameter int RO_BASE    = 'h40,
    parameter int RO_LIMIT   = 'h4F
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [PADDR_W-1:0]        PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic                      b_en,
    input  logic [$clog2(DEPTH)-1:0]  b_addr,
    output logic [DATA_WIDTH-1:0]     b_rdata,
    output logic                      b_rvalid,
    output logic                      b_err,
    output logic [ERR_CNT_W-1:0]      err_cnt
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    // Setup-phase decode, done at 64 bits so DEPTH and the RO window
    // compare cleanly against any PADDR_W.
    logic [63:0] paddr_ext;
    logic [63:0] idx_ext;
    logic        setup_err;

    assign paddr_ext = 64'(PADDR);
    assign idx_ext   = paddr_ext >> LSB;
    assign setup_err = is_misaligned(paddr_ext, LSB)
                     | (idx_ext >= 64'(DEPTH))
                     | (PWRITE & (idx_ext >= 64'(RO_BASE)) & (idx_ext <= 64'(RO_LIMIT)))
                     | (!PWRITE & (PSTRB != '0));

    apb_mem_state_t     state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic [PADDR_W-1:0] lat_addr;
    logic               lat_write;
    logic               lat_err;
    logic [AW-1:0]      lat_idx;
    logic               load;
    logic               ready;
    logic               violation;
    logic               err_inc;

    // Anything that changes the transfer mid-flight aborts it.
    assign violation = !PSEL | !PENABLE | (PADDR != lat_addr) | (PWRITE != lat_write);

    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    load       = 1'b1;
                    state_next = ACCESS;
                    cnt_next   = setup_err ? 4'd0 : (PWRITE ? WR_CNT : RD_CNT);
                end
            end
            ACCESS: begin
                if (violation) begin
                    state_next = ABORT;
                end else if (cnt == 4'd0) begin
                    ready      = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ABORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) begin
                lat_addr  <= PADDR;
                lat_write <= PWRITE;
                lat_err   <= setup_err;
                lat_idx   <= AW'(idx_ext);
            end
        end
    end

    // The abort is counted during the single ABORT cycle.
    assign err_inc = (ready & lat_err) | (state == ABORT);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            err_cnt <= '0;
        end else if (err_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    // Port B: out-of-range requests never touch the array.
    logic                  b_oor;
    logic [DATA_WIDTH-1:0] ram_a_rdata;
    logic [DATA_WIDTH-1:0] ram_b_rdata;

    assign b_oor = 64'(b_addr) >= 64'(DEPTH);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            b_rvalid <= 1'b0;
            b_err    <= 1'b0;
        end else begin
            b_rvalid <= b_en;
            b_err    <= b_en & b_oor;
        end
    end

    apb_dp_mem_v2_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (PCLK),
        .rst     (PRESET),
        .we      (ready & lat_write & !lat_err),
        .wbe     (PSTRB),
        .a_addr  (lat_idx),
        .wdata   (PWDATA),
        .a_rdata (ram_a_rdata),
        .b_en    (b_en & !b_oor),
        .b_addr  (b_addr),
        .b_rdata (ram_b_rdata)
    );

    assign PREADY  = ready;
    assign PSLVERR = ready & lat_err;
    assign PRDATA  = (ready & !lat_write & !lat_err) ? ram_a_rdata : '0;
    assign b_rdata = b_err ? '0 : ram_b_rdata;

endmodule

// File: tb/tb_apb_dp_mem_v2.sv
module tb_apb_dp_mem_v2;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        b_en;
    logic [7:0]  b_addr;
    logic [31:0] b_rdata;
    logic        b_rvalid, b_err;
    logic [7:0]  err_cnt;

    // Second instance with DEPTH=300 so port B can address past the end.
    logic        b_en2;
    logic [8:0]  b_addr2;
    logic [31:0] b_rdata2, prdata2;
    logic        b_rvalid2, b_err2, pready2, pslverr2;
    logic [7:0]  err_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_dp_mem_v2 dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata),
        .b_rvalid(b_rvalid), .b_err(b_err), .err_cnt(err_cnt)
    );

    apb_dp_mem_v2 #(.DEPTH(300)) dut2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(1'b0), .PENABLE(1'b0),
        .PWRITE(1'b0), .PADDR(12'h0), .PWDATA(32'h0), .PSTRB(4'h0),
        .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2),
        .b_en(b_en2), .b_addr(b_addr2), .b_rdata(b_rdata2),
        .b_rvalid(b_rvalid2), .b_err(b_err2), .err_cnt(err_cnt2)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        slverr;
        int          lat;
    } apb_exp_t;

    apb_exp_t    apb_sb[$];
    logic [31:0] b_sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One APB transfer. The expected response is queued at setup and popped
    // when PREADY is seen; the latency is the ACCESS cycle number.
    task automatic apb_xfer(input logic wr, input logic [11:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input string tag, input logic [31:0] exp_rdata,
                            input logic exp_err, input int exp_lat,
                            input logic collide = 1'b0,
                            input logic [31:0] b_exp = 32'h0);
        apb_exp_t e;
        int       n;
        logic     done;
        apb_sb.push_back('{tag, exp_rdata, exp_err, exp_lat});
        if (collide) b_sb.push_back(b_exp);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            n++;
            @(negedge PCLK);
            if (PREADY) begin
                done = 1'b1;
                e = apb_sb.pop_front();
                check($sformatf("%s_lat", e.tag), 64'(n), 64'(e.lat));
                check($sformatf("%s_slverr", e.tag), PSLVERR, e.slverr);
                check($sformatf("%s_prdata", e.tag), PRDATA, e.rdata);
                if (collide) begin
                    b_en = 1'b1;
                    b_addr = addr[9:2];
                end
            end else begin
                check($sformatf("%s_slverr_wait", tag), PSLVERR, 1'b0);
            end
        end
        if (!done) begin
            e = apb_sb.pop_front();
            check($sformatf("%s_timeout", e.tag), 1'b0, 1'b1);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PSTRB = 4'h0; b_en = 1'b0;
        if (collide) begin
            @(negedge PCLK);
            check($sformatf("%s_b_rvalid", tag), b_rvalid, 1'b1);
            check($sformatf("%s_b_rdata", tag), b_rdata, b_sb.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        b_en = 1'b0; b_addr = '0; b_en2 = 1'b0; b_addr2 = '0;

        // Reset state
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_pready", PREADY, 1'b0);
        check("rst_pslverr", PSLVERR, 1'b0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_b_rvalid", b_rvalid, 1'b0);
        check("rst_b_err", b_err, 1'b0);
        check("rst_b_rdata", b_rdata, 32'h0);
        check("rst_err_cnt", err_cnt, 8'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Normal write/read
        apb_xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, "wr010", 32'h0, 1'b0, 4);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, "rd010", 32'hDEADBEEF, 1'b0, 2);

        // Partial strobe: lanes 0 and 2 take the new bytes
        apb_xfer(1'b1, 12'h020, 32'h11223344, 4'hF, "wr020", 32'h0, 1'b0, 4);
        apb_xfer(1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, "wr020p", 32'h0, 1'b0, 4);
        apb_xfer(1'b0, 12'h020, 32'h0, 4'h0, "rd020", 32'h11BB33DD, 1'b0, 2);

        // Error completions
        apb_xfer(1'b1, 12'h100, 32'hBADC0DE0, 4'hF, "wr_ro", 32'h0, 1'b1, 1);
        check("err_cnt_1", err_cnt, 8'd1);
        @(posedge PCLK); #1;
        b_en = 1'b1; b_addr = 8'h40;
        @(posedge PCLK); #1;
        b_en = 1'b0;
        @(negedge PCLK);
        check("ro_unchanged", (b_rdata !== 32'hBADC0DE0), 1'b1);
        apb_xfer(1'b0, 12'h402, 32'h0, 4'h0, "rd_misal", 32'h0, 1'b1, 1);
        check("err_cnt_2", err_cnt, 8'd2);
        apb_xfer(1'b0, 12'h400, 32'h0, 4'h0, "rd_oor", 32'h0, 1'b1, 1);
        check("err_cnt_3", err_cnt, 8'd3);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h1, "rd_strb", 32'h0, 1'b1, 1);
        check("err_cnt_4", err_cnt, 8'd4);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, "rd010_again", 32'hDEADBEEF, 1'b0, 2);

        // Port B collision: read-before-write on the commit edge
        apb_xfer(1'b1, 12'h014, 32'h1, 4'hF, "wr5_pre", 32'h0, 1'b0, 4);
        apb_xfer(1'b1, 12'h014, 32'h2, 4'hF, "wr5_col", 32'h0, 1'b0, 4, 1'b1, 32'h1);

        // Back-to-back port B requests
        @(posedge PCLK); #1;
        b_en = 1'b1; b_addr = 8'd5; b_sb.push_back(32'h2);
        @(posedge PCLK); #1;
        b_addr = 8'd4; b_sb.push_back(32'hDEADBEEF);
        @(negedge PCLK);
        check("b_burst0_rvalid", b_rvalid, 1'b1);
        check("b_burst0_rdata", b_rdata, b_sb.pop_front());
        @(posedge PCLK); #1;
        b_en = 1'b0;
        @(negedge PCLK);
        check("b_burst1_rvalid", b_rvalid, 1'b1);
        check("b_burst1_rdata", b_rdata, b_sb.pop_front());
        @(negedge PCLK);
        check("b_pulse_end", b_rvalid, 1'b0);

        // Port B out of range on the DEPTH=300 instance
        @(posedge PCLK); #1;
        b_en2 = 1'b1; b_addr2 = 9'd300;
        @(posedge PCLK); #1;
        b_en2 = 1'b0;
        @(negedge PCLK);
        check("b_oor_rvalid", b_rvalid2, 1'b1);
        check("b_oor_err", b_err2, 1'b1);
        check("b_oor_rdata", b_rdata2, 32'h0);

        // Protocol abort: PSEL dropped in ACCESS cycle 2
        apb_xfer(1'b1, 12'h030, 32'hCAFE0030, 4'hF, "wr030", 32'h0, 1'b0, 4);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 12'h030; PWDATA = 32'h0BAD0BAD; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("abort_c1_pready", PREADY, 1'b0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PSTRB = 4'h0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("abort_pready", PREADY, 1'b0);
        @(posedge PCLK);
        @(negedge PCLK);
        check("abort_err_cnt", err_cnt, 8'd5);
        apb_xfer(1'b0, 12'h030, 32'h0, 4'h0, "rd030_after_abort", 32'hCAFE0030, 1'b0, 2);

        // Reset in ACCESS cycle 2 of a write
        apb_xfer(1'b1, 12'h040, 32'h5555AAAA, 4'hF, "wr040", 32'h0, 1'b0, 4);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 12'h040; PWDATA = 32'h12345678; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #2;
        PRESET = 1'b1;
        #1;
        check("rstmid_pready", PREADY, 1'b0);
        check("rstmid_pslverr", PSLVERR, 1'b0);
        check("rstmid_prdata", PRDATA, 32'h0);
        check("rstmid_err_cnt", err_cnt, 8'h0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PSTRB = 4'h0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        apb_xfer(1'b0, 12'h040, 32'h0, 4'h0, "rd040_after_rst", 32'h5555AAAA, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
